alu_exec_unit: RTL and testbench

Execute-stage arithmetic unit of the pipelined ARM-subset CPU. It contains three parts:
- an ARM-style barrel shifter on operand B;
- a 16-operation ALU;
- the registered ALU result (ALUout) and the CPSR condition-flag register (N, Z, C, V).

It sits between the ID/EX operand registers and the MEM stage. The held C flag feeds back as carry-in for ADC/SBC/RSC.

---
 rtl/alu_exec_pkg.sv | 37 +++
 rtl/alu_exec_if.sv | 25 ++
 rtl/alu_exec_unit_barrel_shifter.sv | 88 ++++++++
 rtl/alu_exec_unit.sv | 94 +++++++++
 tb/tb_alu_exec_unit.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/alu_exec_pkg.sv
// Shared constants for the execute-stage ALU: opcodes, shift types and
// instruction bit positions.
package alu_exec_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  localparam int IR_I          = 25;
  localparam int IR_S          = 20;
  localparam int IR_SH_AMT_HI  = 11;
  localparam int IR_SH_AMT_LO  = 7;
  localparam int IR_SH_TYPE_HI = 6;
  localparam int IR_SH_TYPE_LO = 5;
  localparam int IR_SH_REG     = 4;

endpackage

// File: rtl/alu_exec_if.sv
// Operand, control and result bundle between ID/EX and the execute ALU.
interface alu_exec_if;
  logic [31:0] A;
  logic [31:0] b;
  logic [3:0]  ALUop;
  logic        s;
  logic [31:0] EX_IR;
  logic [7:0]  Rs;
  logic [31:0] Rm;
  logic        MSR;
  logic [31:0] S;
  logic        N, Z, C, V;
  logic [31:0] ALUout;
  logic        Nout, Zout, Cout, Vout;

  modport master (
    output A, b, ALUop, s, EX_IR, Rs, Rm, MSR,
    input  S, N, Z, C, V, ALUout, Nout, Zout, Cout, Vout
  );

  modport slave (
    input  A, b, ALUop, s, EX_IR, Rs, Rm, MSR,
    output S, N, Z, C, V, ALUout, Nout, Zout, Cout, Vout
  );
endinterface

// File: rtl/alu_exec_unit_barrel_shifter.sv
// ARM operand-2 barrel shifter, including the immediate #0 encodings
// (LSR/ASR #32, RRX) and the register-amount saturation rules.
module barrel_shifter
  import alu_exec_pkg::*;
(
  input  logic [31:0] b,
  input  shift_t      shift_type,
  input  logic [7:0]  amount,
  input  logic        reg_amt,
  input  logic        cin,
  output logic [31:0] result,
  output logic        carry
);

  logic [4:0] n5;
  logic [4:0] n_m1;
  logic [4:0] n_neg;

  assign n5    = amount[4:0];
  assign n_m1  = n5 - 5'd1;
  assign n_neg = 5'd0 - n5;   // 32-n modulo 32, valid for n in 1..31

  always_comb begin
    result = b;
    carry  = cin;
    if (amount == 8'd0) begin
      if (!reg_amt) begin
        case (shift_type)
          SH_LSL: begin result = b;                   carry = cin;   end
          SH_LSR: begin result = '0;                  carry = b[31]; end
          SH_ASR: begin result = {32{b[31]}};         carry = b[31]; end
          SH_ROR: begin result = {cin, b[31:1]};      carry = b[0];  end
          default: begin result = b;                  carry = cin;   end
        endcase
      end
    end else begin
      case (shift_type)
        SH_LSL: begin
          if (amount < 8'd32) begin
            result = b << n5;
            carry  = b[n_neg];
          end else if (amount == 8'd32) begin
            result = '0;
            carry  = b[0];
          end else begin
            result = '0;
            carry  = 1'b0;
          end
        end
        SH_LSR: begin
          if (amount < 8'd32) begin
            result = b >> n5;
            carry  = b[n_m1];
          end else if (amount == 8'd32) begin
            result = '0;
            carry  = b[31];
          end else begin
            result = '0;
            carry  = 1'b0;
          end
        end
        SH_ASR: begin
          if (amount < 8'd32) begin
            result = $signed(b) >>> n5;
            carry  = b[n_m1];
          end else begin
            result = {32{b[31]}};
            carry  = b[31];
          end
        end
        SH_ROR: begin
          if (n5 == 5'd0) begin
            result = b;
            carry  = b[31];
          end else begin
            result = (b >> n5) | (b << n_neg);
            carry  = b[n_m1];
          end
        end
        default: begin
          result = b;
          carry  = cin;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: shifter on operand B, 16-op ALU, registered result and
// the CPSR N/Z/C/V flags.
module alu_exec_unit
  import alu_exec_pkg::*;
(
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);

  logic [31:0] shifted, sh;
  logic        shift_c, sh_c;
  logic [7:0]  amt;
  shift_t      sh_type;

  logic [31:0] alu_q;
  logic [3:0]  flags_q;   // {N, Z, C, V}
  logic        c_held, v_held;

  logic [31:0] x, y, res;
  logic        ci, arith;
  logic [32:0] sum;

  assign c_held  = flags_q[1];
  assign v_held  = flags_q[0];
  assign sh_type = shift_t'(bus.EX_IR[IR_SH_TYPE_HI:IR_SH_TYPE_LO]);
  assign amt     = bus.EX_IR[IR_SH_REG] ? bus.Rs
                                        : {3'b000, bus.EX_IR[IR_SH_AMT_HI:IR_SH_AMT_LO]};

  barrel_shifter u_shift (
    .b          (bus.b),
    .shift_type (sh_type),
    .amount     (amt),
    .reg_amt    (bus.EX_IR[IR_SH_REG]),
    .cin        (c_held),
    .result     (shifted),
    .carry      (shift_c)
  );

  assign sh   = bus.EX_IR[IR_I] ? bus.b  : shifted;
  assign sh_c = bus.EX_IR[IR_I] ? c_held : shift_c;

  // Subtraction is X + ~Y + cin so that the adder carry is NOT borrow.
  always_comb begin
    x     = bus.A;
    y     = sh;
    ci    = 1'b0;
    arith = 1'b1;
    res   = '0;
    case (bus.ALUop)
      OP_AND, OP_TST: begin arith = 1'b0; res = bus.A & sh;  end
      OP_EOR, OP_TEQ: begin arith = 1'b0; res = bus.A ^ sh;  end
      OP_SUB, OP_CMP: begin y = ~sh; ci = 1'b1;              end
      OP_RSB:         begin x = sh; y = ~bus.A; ci = 1'b1;   end
      OP_ADD, OP_CMN: begin ci = 1'b0;                       end
      OP_ADC:         begin ci = c_held;                     end
      OP_SBC:         begin y = ~sh; ci = c_held;            end
      OP_RSC:         begin x = sh; y = ~bus.A; ci = c_held; end
      OP_ORR:         begin arith = 1'b0; res = bus.A | sh;  end
      OP_MOV:         begin arith = 1'b0; res = sh;          end
      OP_BIC:         begin arith = 1'b0; res = bus.A & ~sh; end
      OP_MVN:         begin arith = 1'b0; res = ~sh;         end
      default:        begin arith = 1'b0; res = sh;          end
    endcase
    sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    if (arith) res = sum[31:0];
  end

  assign bus.S = res;
  assign bus.N = res[31];
  assign bus.Z = (res == 32'd0);
  assign bus.C = arith ? sum[32] : sh_c;
  assign bus.V = arith ? ((x[31] == y[31]) && (sum[31] != x[31])) : v_held;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q   <= '0;
      flags_q <= '0;
    end else begin
      alu_q <= res;
      if (bus.MSR)
        flags_q <= bus.Rm[31:28];
      else if (bus.s)
        flags_q <= {bus.N, bus.Z, bus.C, bus.V};
    end
  end

  assign bus.ALUout = alu_q;
  assign bus.Nout   = flags_q[3];
  assign bus.Zout   = flags_q[2];
  assign bus.Cout   = flags_q[1];
  assign bus.Vout   = flags_q[0];

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors push expected
// combinational and registered results, two monitors pop and compare.
module tb_alu_exec_unit;

  logic clk;
  logic rst;
  alu_exec_if bus();

  alu_exec_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
    logic [3:0]  f;
  } exp_t;

  exp_t comb_q[$];
  exp_t reg_q[$];
  int   n_pass;
  int   n_total;

  localparam logic [31:0] IMM = 32'h0200_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] bv,
                       input logic [3:0] op, input logic sv, input logic [31:0] ir,
                       input logic [7:0] rs, input logic [31:0] rm, input logic msr,
                       input logic [31:0] exp_s, input logic [3:0] exp_nzcv,
                       input logic [3:0] exp_flags);
    exp_t e;
    @(negedge clk);
    bus.A = a; bus.b = bv; bus.ALUop = op; bus.s = sv; bus.EX_IR = ir;
    bus.Rs = rs; bus.Rm = rm; bus.MSR = msr;
    e.name = name; e.val = exp_s; e.f = exp_nzcv;
    comb_q.push_back(e);
    e.f = exp_flags;
    reg_q.push_back(e);
  endtask

  // Combinational outputs sampled mid low phase
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (comb_q.size() > 0) begin
        e = comb_q.pop_front();
        check({e.name, ".S"}, bus.S, e.val);
        check({e.name, ".nzcv"}, {28'd0, bus.N, bus.Z, bus.C, bus.V}, {28'd0, e.f});
      end
    end
  end

  // Registered outputs sampled just after the rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        e = reg_q.pop_front();
        check({e.name, ".ALUout"}, bus.ALUout, e.val);
        check({e.name, ".flags"}, {28'd0, bus.Nout, bus.Zout, bus.Cout, bus.Vout}, {28'd0, e.f});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b0;
    bus.A = '0; bus.b = '0; bus.ALUop = OP_AND_TB(); bus.s = 1'b0;
    bus.EX_IR = '0; bus.Rs = '0; bus.Rm = '0; bus.MSR = 1'b0;
    #2;
    check("por.ALUout", bus.ALUout, 32'd0);
    check("por.flags", {28'd0, bus.Nout, bus.Zout, bus.Cout, bus.Vout}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    //     name           A             b             op    s     EX_IR        Rs     Rm            MSR   S             nzcv     flags
    issue("add_ovf",  32'h7FFFFFFF, 32'h00000001, 4'h4, 1'b1, IMM,         8'd0,  32'h0,        1'b0, 32'h80000000, 4'b1001, 4'b1001);
    issue("cmp_eq",   32'd5,        32'd5,        4'hA, 1'b1, IMM,         8'd0,  32'h0,        1'b0, 32'h00000000, 4'b0110, 4'b0110);
    issue("adc_c1",   32'd1,        32'd1,        4'h5, 1'b0, IMM,         8'd0,  32'h0,        1'b0, 32'h00000003, 4'b0000, 4'b0110);
    issue("lsl4",     32'd0,        32'hF0000001, 4'hD, 1'b1, 32'h200,     8'd0,  32'h0,        1'b0, 32'h00000010, 4'b0010, 4'b0010);
    issue("lsl4_nos", 32'd0,        32'h00000001, 4'hD, 1'b0, 32'h200,     8'd0,  32'h0,        1'b0, 32'h00000010, 4'b0000, 4'b0010);
    issue("lsr_imm0", 32'd0,        32'h80000000, 4'hD, 1'b1, 32'h20,      8'd0,  32'h0,        1'b0, 32'h00000000, 4'b0110, 4'b0110);
    issue("asr_r40",  32'd0,        32'h80000000, 4'hD, 1'b1, 32'h50,      8'd40, 32'h0,        1'b0, 32'hFFFFFFFF, 4'b1010, 4'b1010);
    issue("rrx",      32'd0,        32'h00000003, 4'hD, 1'b1, 32'h60,      8'd0,  32'h0,        1'b0, 32'h80000001, 4'b1010, 4'b1010);
    issue("lsl_r32",  32'd0,        32'h00000001, 4'hD, 1'b1, 32'h10,      8'd32, 32'h0,        1'b0, 32'h00000000, 4'b0110, 4'b0110);
    issue("lsr_r33",  32'd0,        32'hFFFFFFFF, 4'hD, 1'b1, 32'h30,      8'd33, 32'h0,        1'b0, 32'h00000000, 4'b0100, 4'b0100);
    issue("lsr_r0",   32'd0,        32'h12345678, 4'hD, 1'b1, 32'h30,      8'd0,  32'h0,        1'b0, 32'h12345678, 4'b0000, 4'b0000);
    issue("ror_r32",  32'd0,        32'h80000000, 4'hD, 1'b1, 32'h70,      8'd32, 32'h0,        1'b0, 32'h80000000, 4'b1010, 4'b1010);
    issue("ror_r4",   32'd0,        32'h0000001F, 4'hD, 1'b1, 32'h70,      8'd4,  32'h0,        1'b0, 32'hF0000001, 4'b1010, 4'b1010);
    issue("sub_brw",  32'd3,        32'd5,        4'h2, 1'b1, IMM,         8'd0,  32'h0,        1'b0, 32'hFFFFFFFE, 4'b1000, 4'b1000);
    issue("sbc_c0",   32'd10,       32'd3,        4'h6, 1'b1, IMM,         8'd0,  32'h0,        1'b0, 32'h00000006, 4'b0010, 4'b0010);
    issue("rsb",      32'd1,        32'h10,       4'h3, 1'b1, IMM,         8'd0,  32'h0,        1'b0, 32'h0000000F, 4'b0010, 4'b0010);
    issue("rsc_c1",   32'd2,        32'd1,        4'h7, 1'b1, IMM,         8'd0,  32'h0,        1'b0, 32'hFFFFFFFF, 4'b1000, 4'b1000);
    issue("mvn",      32'd0,        32'd0,        4'hF, 1'b1, IMM,         8'd0,  32'h0,        1'b0, 32'hFFFFFFFF, 4'b1000, 4'b1000);
    issue("bic",      32'hFF,       32'h0F,       4'hE, 1'b0, IMM,         8'd0,  32'h0,        1'b0, 32'h000000F0, 4'b0000, 4'b1000);
    issue("orr",      32'hF0,       32'h0F,       4'hC, 1'b0, IMM,         8'd0,  32'h0,        1'b0, 32'h000000FF, 4'b0000, 4'b1000);
    issue("msr_prio", 32'd0,        32'd0,        4'h4, 1'b1, IMM,         8'd0,  32'hA0000000, 1'b1, 32'h00000000, 4'b0100, 4'b1010);
    issue("add_ovf2", 32'h7FFFFFFF, 32'h00000001, 4'h4, 1'b1, IMM,         8'd0,  32'h0,        1'b0, 32'h80000000, 4'b1001, 4'b1001);
    issue("and_vhold",32'hFFFFFFFF, 32'h80000000, 4'h0, 1'b1, IMM,         8'd0,  32'h0,        1'b0, 32'h80000000, 4'b1001, 4'b1001);
    issue("cmn",      32'hFFFFFFFF, 32'h00000001, 4'hB, 1'b1, IMM,         8'd0,  32'h0,        1'b0, 32'h00000000, 4'b0110, 4'b0110);
    issue("teq",      32'd5,        32'd5,        4'h9, 1'b1, IMM,         8'd0,  32'h0,        1'b0, 32'h00000000, 4'b0110, 4'b0110);
    issue("rst_setup",32'd0,        32'h00001234, 4'hD, 1'b0, IMM,         8'd0,  32'hF0000000, 1'b1, 32'h00001234, 4'b0010, 4'b1111);

    @(negedge clk);
    bus.MSR = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_async.ALUout", bus.ALUout, 32'd0);
    check("rst_async.flags", {28'd0, bus.Nout, bus.Zout, bus.Cout, bus.Vout}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_held.ALUout", bus.ALUout, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("comb_q_drained", comb_q.size(), 32'd0);
    check("reg_q_drained", reg_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  function automatic logic [3:0] OP_AND_TB();
    return 4'h0;
  endfunction

endmodule
